alu_sequencer: RTL

Instruction-driven front end for the 8-bit ALU. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8×8 register file. It drives the ALU's function-select and operand inputs, samples the ALU result and status flags, and writes them back. It sits between the instruction source (test driver or future fetch unit) and the ALU, and is the only block that drives the ALU inputs.

---
 rtl/alu_seq_pkg.sv | 44 ++++
 rtl/alu_seq_regfile.sv | 65 ++++++
 rtl/alu_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, instruction field positions, SREG bits and
// sequencer state encoding shared by the ALU sequencer files.
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SBC = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1000;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RA_HI  = 8;
    localparam int RA_LO  = 6;
    localparam int RB_HI  = 5;
    localparam int RB_LO  = 3;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam int SREG_Z = 0;
    localparam int SREG_C = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;

    localparam int REG_COUNT = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE,
        COMMIT
    } seq_state_t;

    function automatic logic op_is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_AND);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 8x8 register file, two registered-address read ports,
// one debug read port, one write port. ALU_SEQ_R0_ZERO_EN hardwires R0.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       addr_load,
    input  logic [2:0] sel_a,
    input  logic [2:0] sel_b,
    output logic [7:0] rd_a,
    output logic [7:0] rd_b,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    logic [7:0] regs [REG_COUNT];
    logic [2:0] sel_a_q;
    logic [2:0] sel_b_q;
    logic       write_ok;

`ifdef ALU_SEQ_R0_ZERO_EN
    assign write_ok = we && (waddr != 3'd0);
`else
    assign write_ok = we;
`endif

    // Read addresses captured when an instruction is accepted
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_a_q <= 3'd0;
            sel_b_q <= 3'd0;
        end else if (addr_load) begin
            sel_a_q <= sel_a;
            sel_b_q <= sel_b;
        end
    end

    // Register storage: synchronous clear and single write port
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (write_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // Combinational reads; R0 forced to zero when hardwired
    always_comb begin
        rd_a     = regs[sel_a_q];
        rd_b     = regs[sel_b_q];
        dbg_data = regs[dbg_addr];
`ifdef ALU_SEQ_R0_ZERO_EN
        if (sel_a_q == 3'd0) rd_a = 8'h00;
        if (sel_b_q == 3'd0) rd_b = 8'h00;
        if (dbg_addr == 3'd0) dbg_data = 8'h00;
`endif
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state instruction front end driving the 8-bit ALU.
// Optional feature macro: ALU_SEQ_R0_ZERO_EN (R0 hardwired to zero).
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic        instr_ready,
    output logic [3:0]  alu_fsel,
    output logic [7:0]  alu_op_a,
    output logic [7:0]  alu_op_b,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_sreg,
    output logic        wb_valid,
    output logic [2:0]  wb_addr,
    output logic [7:0]  wb_data,
    output logic [3:0]  flags,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    seq_state_t state;
    seq_state_t state_nx;

    logic [3:0] op_q;
    logic [2:0] rd_q;
    logic [7:0] imm_q;
    logic       accept;
    logic       is_alu;
    logic       writes;
    logic       rf_we;
    logic [7:0] wr_data;
    logic [7:0] ra_data;
    logic [7:0] rb_data;

    assign accept = instr_valid & instr_ready;
    assign rf_we  = (state == COMMIT) & writes;

    alu_seq_regfile u_regfile (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr_load (accept),
        .sel_a     (instr_data[RA_HI:RA_LO]),
        .sel_b     (instr_data[RB_HI:RB_LO]),
        .rd_a      (ra_data),
        .rd_b      (rb_data),
        .we        (rf_we),
        .waddr     (rd_q),
        .wdata     (wr_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and handshake; every opcode walks all four states
    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nx = ISSUE;
            end
            ISSUE:   state_nx = SETTLE;
            SETTLE:  state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Opcode decode: ALU issue, register write and write-back source
    always_comb begin
        is_alu  = 1'b0;
        writes  = 1'b0;
        wr_data = alu_result;
        unique case (1'b1)
            op_is_alu(op_q): begin
                is_alu = 1'b1;
                writes = (op_q != OP_CMP);
            end
            (op_q == OP_LDI): begin
                writes  = 1'b1;
                wr_data = imm_q;
            end
            default: ;
        endcase
    end

    // Latch the instruction fields on the accepting edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q  <= OP_NOP;
            rd_q  <= 3'd0;
            imm_q <= 8'h00;
        end else if (accept) begin
            op_q  <= instr_data[OPC_HI:OPC_LO];
            rd_q  <= instr_data[RD_HI:RD_LO];
            imm_q <= instr_data[IMM_HI:IMM_LO];
        end
    end

    // ALU inputs: loaded in ISSUE for ALU ops, otherwise held so carry chains survive
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alu_fsel <= 4'b0000;
            alu_op_a <= 8'h00;
            alu_op_b <= 8'h00;
        end else if ((state == ISSUE) && is_alu) begin
            alu_fsel <= op_q;
            alu_op_a <= ra_data;
            alu_op_b <= rb_data;
        end
    end

    // Commit: capture flags and emit the one-cycle write-back pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags    <= 4'h0;
            wb_valid <= 1'b0;
            wb_addr  <= 3'd0;
            wb_data  <= 8'h00;
        end else begin
            wb_valid <= 1'b0;
            if (state == COMMIT) begin
                if (is_alu) flags <= alu_sreg;
                if (writes) begin
                    wb_valid <= 1'b1;
                    wb_addr  <= rd_q;
                    wb_data  <= wr_data;
                end
            end
        end
    end

endmodule
